voice_reg_bank: RTL and testbench

- Parametrised bus-slave register bank holding the per-voice control registers for NUM_VOICES synth voices.
- Samples the asynchronous byte-wide bus (BusAddress/BusData/BusReadWrite/BusClock) into the Clock domain.
- Assembles 24-bit parameters atomically and drives flattened per-voice outputs to the oscillator/envelope datapaths.
- Adds readback, atomic multi-byte commit and gate-edge strobes with retrigger.

---
 rtl/voice_reg_bank.sv | 198 +++++++++++++++++++
 tb/tb_voice_reg_bank.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_reg_bank.sv
// Per-voice control register bank for the synth voices.
// Byte-wide asynchronous bus is sampled into the Clock domain; 24-bit
// parameters are assembled through shared staging bytes and committed in
// one cycle on the high-byte write. Gate writes produce note-on/off strobes.
//
// Bus semantics: a write is requested by a rising edge of BusClock while
// BusReadWrite=1. BusAddress/BusDataIn must be held from that rise until
// 4 Clock cycles later. There is no ready/acknowledge; the write executes
// two Clock edges after the rise is first sampled. Reads are purely
// address-driven: BusDataOut/BusDataOE follow BusAddress/BusReadWrite one
// Clock later, with BusDataOE=1 only for a read of a mapped byte.
module voice_reg_bank #(
  parameter int          NUM_VOICES   = 4,
  parameter logic [15:0] VOICE_BASE   = 16'h0010,
  parameter logic [15:0] VOICE_STRIDE = 16'h0020
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [15:0]             BusAddress,
  input  logic [7:0]              BusDataIn,
  output logic [7:0]              BusDataOut,
  output logic                    BusDataOE,
  input  logic                    BusReadWrite,
  input  logic                    BusClock,
  output logic [NUM_VOICES-1:0]   Gate,
  output logic [NUM_VOICES-1:0]   GateOn,
  output logic [NUM_VOICES-1:0]   GateOff,
  output logic [24*NUM_VOICES-1:0] Incr,
  output logic [24*NUM_VOICES-1:0] PulseWidth,
  output logic [24*NUM_VOICES-1:0] Attack,
  output logic [24*NUM_VOICES-1:0] Decay,
  output logic [24*NUM_VOICES-1:0] Sustain,
  output logic [24*NUM_VOICES-1:0] Release,
  output logic [2*NUM_VOICES-1:0]  WaveType,
  output logic [NUM_VOICES-1:0]   Linear
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic s1, s2, s3;
  logic wr_pulse;

  logic          hit;
  logic [VW-1:0] hit_voice;
  logic [4:0]    hit_off;
  logic [31:0]   vbase;
  logic [31:0]   rel;
  logic [7:0]    rd_byte;

  logic [7:0]  stage_lo, stage_mid;
  logic [23:0] incr_q    [NUM_VOICES];
  logic [23:0] pw_q      [NUM_VOICES];
  logic [23:0] attack_q  [NUM_VOICES];
  logic [23:0] decay_q   [NUM_VOICES];
  logic [23:0] sustain_q [NUM_VOICES];
  logic [23:0] release_q [NUM_VOICES];
  logic [1:0]  wave_q    [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, linear_q, on_q, off_q;

  // Bring BusClock into the Clock domain and keep one history bit for edge detect.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= BusClock;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign wr_pulse = s2 & ~s3 & BusReadWrite;

  // Address decode: find which voice block (if any) the address falls in.
  always_comb begin
    hit       = 1'b0;
    hit_voice = '0;
    hit_off   = '0;
    vbase     = '0;
    rel       = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      vbase = 32'(VOICE_BASE) + 32'(v) * 32'(VOICE_STRIDE);
      rel   = 32'(BusAddress) - vbase;
      if ((32'(BusAddress) >= vbase) && (rel < 32'h15)) begin
        hit       = 1'b1;
        hit_voice = VW'(v);
        hit_off   = rel[4:0];
      end
    end
  end

  // Register writes, 24-bit staging/commit and gate-edge strobes.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stage_lo  <= '0;
      stage_mid <= '0;
      gate_q    <= '0;
      linear_q  <= '0;
      on_q      <= '0;
      off_q     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        incr_q[v]    <= '0;
        pw_q[v]      <= '0;
        attack_q[v]  <= '0;
        decay_q[v]   <= '0;
        sustain_q[v] <= '0;
        release_q[v] <= '0;
        wave_q[v]    <= '0;
      end
    end else begin
      on_q  <= '0;
      off_q <= '0;
      if (wr_pulse && hit) begin
        case (hit_off)
          5'h00: begin
            if (BusDataIn[0] && !gate_q[hit_voice]) begin
              gate_q[hit_voice] <= 1'b1;
              on_q[hit_voice]   <= 1'b1;
            end else if (!BusDataIn[0] && gate_q[hit_voice]) begin
              gate_q[hit_voice] <= 1'b0;
              off_q[hit_voice]  <= 1'b1;
            end else if (BusDataIn[0] && BusDataIn[1]) begin
              on_q[hit_voice] <= 1'b1;
            end
          end
          5'h01, 5'h05, 5'h08, 5'h0B, 5'h0E, 5'h11: stage_lo  <= BusDataIn;
          5'h02, 5'h06, 5'h09, 5'h0C, 5'h0F, 5'h12: stage_mid <= BusDataIn;
          5'h03: incr_q[hit_voice]    <= {BusDataIn, stage_mid, stage_lo};
          5'h04: wave_q[hit_voice]    <= BusDataIn[1:0];
          5'h07: pw_q[hit_voice]      <= {BusDataIn, stage_mid, stage_lo};
          5'h0A: attack_q[hit_voice]  <= {BusDataIn, stage_mid, stage_lo};
          5'h0D: decay_q[hit_voice]   <= {BusDataIn, stage_mid, stage_lo};
          5'h10: sustain_q[hit_voice] <= {BusDataIn, stage_mid, stage_lo};
          5'h13: release_q[hit_voice] <= {BusDataIn, stage_mid, stage_lo};
          5'h14: linear_q[hit_voice]  <= BusDataIn[0];
          default: ;
        endcase
      end
    end
  end

  // Readback byte select from live registers of the addressed voice.
  always_comb begin
    rd_byte = '0;
    case (hit_off)
      5'h00: rd_byte = {7'b0, gate_q[hit_voice]};
      5'h01: rd_byte = incr_q[hit_voice][7:0];
      5'h02: rd_byte = incr_q[hit_voice][15:8];
      5'h03: rd_byte = incr_q[hit_voice][23:16];
      5'h04: rd_byte = {6'b0, wave_q[hit_voice]};
      5'h05: rd_byte = pw_q[hit_voice][7:0];
      5'h06: rd_byte = pw_q[hit_voice][15:8];
      5'h07: rd_byte = pw_q[hit_voice][23:16];
      5'h08: rd_byte = attack_q[hit_voice][7:0];
      5'h09: rd_byte = attack_q[hit_voice][15:8];
      5'h0A: rd_byte = attack_q[hit_voice][23:16];
      5'h0B: rd_byte = decay_q[hit_voice][7:0];
      5'h0C: rd_byte = decay_q[hit_voice][15:8];
      5'h0D: rd_byte = decay_q[hit_voice][23:16];
      5'h0E: rd_byte = sustain_q[hit_voice][7:0];
      5'h0F: rd_byte = sustain_q[hit_voice][15:8];
      5'h10: rd_byte = sustain_q[hit_voice][23:16];
      5'h11: rd_byte = release_q[hit_voice][7:0];
      5'h12: rd_byte = release_q[hit_voice][15:8];
      5'h13: rd_byte = release_q[hit_voice][23:16];
      5'h14: rd_byte = {7'b0, linear_q[hit_voice]};
      default: rd_byte = '0;
    endcase
  end

  // Registered read port: one Clock of latency, independent of BusClock.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      BusDataOut <= '0;
      BusDataOE  <= 1'b0;
    end else begin
      BusDataOE  <= hit & ~BusReadWrite;
      BusDataOut <= (hit && !BusReadWrite) ? rd_byte : 8'h00;
    end
  end

  assign Gate    = gate_q;
  assign GateOn  = on_q;
  assign GateOff = off_q;
  assign Linear  = linear_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_flat
    assign Incr[24*v +: 24]       = incr_q[v];
    assign PulseWidth[24*v +: 24] = pw_q[v];
    assign Attack[24*v +: 24]     = attack_q[v];
    assign Decay[24*v +: 24]      = decay_q[v];
    assign Sustain[24*v +: 24]    = sustain_q[v];
    assign Release[24*v +: 24]    = release_q[v];
    assign WaveType[2*v +: 2]     = wave_q[v];
  end

endmodule

// File: tb/tb_voice_reg_bank.sv
// Bench for voice_reg_bank: byte-array register model with shared staging,
// per-cycle output comparison, read-data scoreboard and literal anchors.
module tb_voice_reg_bank;

  localparam int NV     = 4;
  localparam int BASE   = 16'h0010;
  localparam int STRIDE = 16'h0020;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  logic [15:0] BusAddress = '0;
  logic [7:0]  BusDataIn = '0;
  logic        BusReadWrite = 1'b0;
  logic        BusClock = 1'b0;
  logic [7:0]  BusDataOut;
  logic        BusDataOE;
  logic [NV-1:0] Gate, GateOn, GateOff, Linear;
  logic [24*NV-1:0] Incr, PulseWidth, Attack, Decay, Sustain, Release;
  logic [2*NV-1:0] WaveType;

  voice_reg_bank #(.NUM_VOICES(NV), .VOICE_BASE(16'h0010), .VOICE_STRIDE(16'h0020)) dut (
    .Clock(Clock), .Reset(Reset), .BusAddress(BusAddress), .BusDataIn(BusDataIn),
    .BusDataOut(BusDataOut), .BusDataOE(BusDataOE), .BusReadWrite(BusReadWrite),
    .BusClock(BusClock), .Gate(Gate), .GateOn(GateOn), .GateOff(GateOff),
    .Incr(Incr), .PulseWidth(PulseWidth), .Attack(Attack), .Decay(Decay),
    .Sustain(Sustain), .Release(Release), .WaveType(WaveType), .Linear(Linear)
  );

  // ---------------- model ----------------
  logic [7:0]    mem [NV][21];
  logic [7:0]    m_lo, m_mid;
  logic [NV-1:0] exp_on, exp_off;
  logic [8:0]    exp_q[$];
  int checks = 0;
  int errors = 0;
  int on_cnt [NV];
  int off_cnt [NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < NV; v++)
      for (int o = 0; o < 21; o++) mem[v][o] = 8'h00;
    m_lo = 8'h00;
    m_mid = 8'h00;
    exp_on = '0;
    exp_off = '0;
  endtask

  function automatic bit decode(input logic [15:0] a, output int v, output int off);
    int r;
    r = int'(a) - BASE;
    v = 0;
    off = 0;
    if (r < 0 || r >= NV * STRIDE) return 1'b0;
    v = r / STRIDE;
    off = r % STRIDE;
    return off < 21;
  endfunction

  function automatic logic [8:0] model_read(input logic [15:0] a);
    int v, off;
    if (!decode(a, v, off)) return 9'h000;
    return {1'b1, mem[v][off]};
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    int v, off, pos;
    if (!decode(a, v, off)) return;
    if (off == 0) begin
      if (d[0] && !mem[v][0][0]) begin
        mem[v][0] = 8'h01; exp_on[v] = 1'b1;
      end else if (!d[0] && mem[v][0][0]) begin
        mem[v][0] = 8'h00; exp_off[v] = 1'b1;
      end else if (d[0] && d[1]) begin
        exp_on[v] = 1'b1;
      end
    end else if (off == 4) begin
      mem[v][4] = d & 8'h03;
    end else if (off == 20) begin
      mem[v][20] = d & 8'h01;
    end else begin
      pos = (off < 4) ? off - 1 : (off < 8) ? off - 5 : (off - 8) % 3;
      if (pos == 0) m_lo = d;
      else if (pos == 1) m_mid = d;
      else begin
        mem[v][off] = d;
        mem[v][off-1] = m_mid;
        mem[v][off-2] = m_lo;
      end
    end
  endtask

  function automatic logic [24*NV-1:0] exp_field(input int b);
    logic [24*NV-1:0] r;
    for (int v = 0; v < NV; v++) r[24*v +: 24] = {mem[v][b+2], mem[v][b+1], mem[v][b]};
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_bit(input int o);
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = mem[v][o][0];
    return r;
  endfunction

  function automatic logic [2*NV-1:0] exp_wave();
    logic [2*NV-1:0] r;
    for (int v = 0; v < NV; v++) r[2*v +: 2] = mem[v][4][1:0];
    return r;
  endfunction

  // ---------------- compare process (every cycle, negedge) ----------------
  always @(negedge Clock) begin
    logic [8:0] e;
    chk("gate", Gate, exp_bit(0));
    chk("gate_on", GateOn, exp_on);
    chk("gate_off", GateOff, exp_off);
    chk("incr", Incr, exp_field(1));
    chk("pulse_width", PulseWidth, exp_field(5));
    chk("attack", Attack, exp_field(8));
    chk("decay", Decay, exp_field(11));
    chk("sustain", Sustain, exp_field(14));
    chk("release", Release, exp_field(17));
    chk("wave_type", WaveType, exp_wave());
    chk("linear", Linear, exp_bit(20));
    for (int v = 0; v < NV; v++) begin
      if (GateOn[v]) on_cnt[v]++;
      if (GateOff[v]) off_cnt[v]++;
    end
    if (!Reset) begin
      exp_q.delete();
      chk("read_in_reset", {BusDataOE, BusDataOut}, 9'h000);
      exp_q.push_back(9'h000);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("read_port", {BusDataOE, BusDataOut}, e);
      end
      exp_q.push_back(BusReadWrite ? 9'h000 : model_read(BusAddress));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge Clock); #1;
    BusAddress = a; BusDataIn = d; BusReadWrite = 1'b1; BusClock = 1'b1;
    repeat (3) @(posedge Clock);
    #1 model_write(a, d);
    @(posedge Clock); #1;
    exp_on = '0; exp_off = '0;
    repeat (2) @(posedge Clock); #1;
    BusClock = 1'b0;
    repeat (3) @(posedge Clock); #1;
    BusReadWrite = 1'b0;
  endtask

  task automatic bus_read_expect(input logic [15:0] a, input logic oe, input logic [7:0] d);
    @(posedge Clock); #1;
    BusAddress = a; BusReadWrite = 1'b0;
    @(posedge Clock);
    @(negedge Clock); #1;
    chk($sformatf("read_%04h", a), {BusDataOE, BusDataOut}, {oe, d});
  endtask

  task automatic do_reset(input int cycles);
    @(posedge Clock); #1;
    Reset = 1'b0;
    model_clear();
    repeat (cycles) @(posedge Clock); #1;
    Reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c_on, c_off, v, off, mode;
    logic [15:0] a;
    for (int i = 0; i < NV; i++) begin on_cnt[i] = 0; off_cnt[i] = 0; end
    model_clear();
    repeat (3) @(posedge Clock); #1;
    Reset = 1'b1;

    // Quiet after reset
    repeat (100) @(posedge Clock);
    @(negedge Clock); #1;
    chk("quiet_incr", Incr, '0);
    chk("quiet_oe", BusDataOE, 1'b0);
    chk("quiet_strobes", on_cnt[0] + on_cnt[1] + on_cnt[2] + on_cnt[3], 0);

    // Staged 24-bit commit on voice 0 Incr
    bus_write(16'h0011, 8'hFF);
    bus_write(16'h0012, 8'hFF);
    chk("incr_staged_only", Incr[23:0], 24'h000000);
    bus_write(16'h0013, 8'h0F);
    chk("incr_commit", Incr[23:0], 24'h0FFFFF);

    // Gate edges on voice 1
    c_on = on_cnt[1]; c_off = off_cnt[1];
    bus_write(16'h0030, 8'h01);
    chk("gate1_on_level", Gate[1], 1'b1);
    chk("gate1_on_pulse", on_cnt[1] - c_on, 1);
    bus_write(16'h0030, 8'h03);
    chk("gate1_retrig_level", Gate[1], 1'b1);
    chk("gate1_retrig_pulse", on_cnt[1] - c_on, 2);
    bus_write(16'h0030, 8'h01);
    chk("gate1_hold_no_pulse", on_cnt[1] - c_on, 2);
    bus_write(16'h0030, 8'h00);
    chk("gate1_off_level", Gate[1], 1'b0);
    chk("gate1_off_pulse", off_cnt[1] - c_off, 1);

    // PulseWidth readback on voice 1
    bus_write(16'h0035, 8'hFF);
    bus_write(16'h0036, 8'hFF);
    bus_write(16'h0037, 8'h7F);
    chk("pw1_value", PulseWidth[47:24], 24'h7FFFFF);
    bus_read_expect(16'h0035, 1'b1, 8'hFF);
    bus_read_expect(16'h0036, 1'b1, 8'hFF);
    bus_read_expect(16'h0037, 1'b1, 8'h7F);
    bus_read_expect(16'h0025, 1'b0, 8'h00);
    bus_read_expect(16'h0030, 1'b1, 8'h00);

    // Unmapped writes
    bus_write(16'h0095, 8'hAA);
    for (int i = 0; i < NV; i++) bus_write(16'(BASE + STRIDE * i + 16'h15), 8'h55);
    chk("gap_incr_kept", Incr[23:0], 24'h0FFFFF);
    chk("gap_pw_kept", PulseWidth[47:24], 24'h7FFFFF);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      mode = $urandom_range(0, 9);
      v = $urandom_range(0, NV - 1);
      if (mode < 3) begin
        off = 1 + 3 * $urandom_range(0, 5);
        if (off == 4) off = 5;
        else if (off > 4) off = off + ((off == 7) ? -2 : 0);
        a = 16'(BASE + STRIDE * v + ((off <= 5) ? off : 8 + ((off - 8) / 3) * 3));
        bus_write(a, 8'($urandom_range(0, 255)));
        bus_write(a + 16'd1, 8'($urandom_range(0, 255)));
        bus_write(a + 16'd2, 8'($urandom_range(0, 255)));
      end else if (mode < 7) begin
        a = 16'(BASE + STRIDE * v + $urandom_range(0, 31));
        bus_write(a, 8'($urandom_range(0, 255)));
      end else if (mode == 7) begin
        a = (($urandom_range(0, 1)) != 0) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(16'h0090, 16'hFFFF));
        bus_write(a, 8'($urandom_range(0, 255)));
      end else begin
        for (int k = 0; k < 4; k++) begin
          @(posedge Clock); #1;
          BusReadWrite = 1'b0;
          BusAddress = 16'($urandom_range(0, 16'h00A0));
        end
      end
    end

    // Reset mid-sequence discards staging and registers
    bus_write(16'h0018, 8'hAB);
    bus_write(16'h0019, 8'hCD);
    bus_write(16'h001A, 8'hEF);
    chk("attack_pre_reset", Attack[23:0], 24'hEFCDAB);
    bus_write(16'h0018, 8'h00);
    bus_write(16'h0019, 8'h00);
    do_reset(3);
    @(negedge Clock); #1;
    chk("post_reset_attack", Attack[23:0], 24'h000000);
    bus_write(16'h001A, 8'h01);
    chk("attack_after_reset", Attack[23:0], 24'h010000);
    chk("incr_after_reset", Incr, '0);
    chk("gate_after_reset", Gate, '0);
    repeat (5) @(posedge Clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
